// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bundle between the decode stage and fwd_hazard_ctrl.
// master = decode/execute side, slave = the hazard controller.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned REG_W = 3,
    parameter int unsigned CNT_W = 16
);
    logic             dec_valid;
    logic [REG_W-1:0] dec_rs;
    logic [REG_W-1:0] dec_rt;
    logic             dec_use_rs;
    logic             dec_use_rt;
    logic [REG_W-1:0] dec_rd;
    logic             dec_wen;
    logic [1:0]       dec_wbsrc;
    logic             flush;
    logic             mem_stall;

    logic             stall_dec;
    logic             forward_XX_A;
    logic             forward_XX_B;
    logic             forward_XM_A;
    logic             forward_XM_B;
    logic [1:0]       forward_XX_sel;
    logic [1:0]       forward_XM_sel;
    logic [CNT_W-1:0] perf_stalls;
    logic [CNT_W-1:0] perf_fwds;

    modport master (
        output dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
               dec_rd, dec_wen, dec_wbsrc, flush, mem_stall,
        input  stall_dec, forward_XX_A, forward_XX_B, forward_XM_A,
               forward_XM_B, forward_XX_sel, forward_XM_sel,
               perf_stalls, perf_fwds
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
               dec_rd, dec_wen, dec_wbsrc, flush, mem_stall,
        output stall_dec, forward_XX_A, forward_XX_B, forward_XM_A,
               forward_XM_B, forward_XX_sel, forward_XM_sel,
               perf_stalls, perf_fwds
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall generator for the execute stage muxes.
// Define FWD_PERF_EN to add saturating stall/forward perf counters.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] SRC_MEM = 2'b10;

    typedef struct packed {
        logic             wen;
        logic [REG_W-1:0] rd;
        logic [1:0]       wbsrc;
    } slot_t;

    slot_t      dx_q, dx_d, xm_q, xm_d, mw_q, mw_d;
    logic       fxx_a_q, fxx_a_d, fxx_b_q, fxx_b_d;
    logic       fxm_a_q, fxm_a_d, fxm_b_q, fxm_b_d;
    logic [1:0] xx_sel_q, xx_sel_d, xm_sel_q, xm_sel_d;

    logic hit_xx_rs, hit_xx_rt, hit_xm_rs, hit_xm_rt;
    logic load_use, bubble, stall_dec_c;

    // Hazard detection of the decode instruction against the shadow slots
    always_comb begin
        hit_xx_rs   = bus.dec_use_rs & dx_q.wen & (dx_q.rd == bus.dec_rs) & (dx_q.wbsrc != SRC_MEM);
        hit_xx_rt   = bus.dec_use_rt & dx_q.wen & (dx_q.rd == bus.dec_rt) & (dx_q.wbsrc != SRC_MEM);
        hit_xm_rs   = bus.dec_use_rs & xm_q.wen & (xm_q.rd == bus.dec_rs);
        hit_xm_rt   = bus.dec_use_rt & xm_q.wen & (xm_q.rd == bus.dec_rt);
        load_use    = bus.dec_valid & dx_q.wen & (dx_q.wbsrc == SRC_MEM)
                    & ((bus.dec_use_rs & (dx_q.rd == bus.dec_rs))
                     | (bus.dec_use_rt & (dx_q.rd == bus.dec_rt)));
        bubble      = bus.flush | load_use;
        stall_dec_c = load_use & ~bus.flush & ~bus.mem_stall;
    end

    // Next state: hold on mem_stall, otherwise advance with optional DX bubble
    always_comb begin
        dx_d     = dx_q;
        xm_d     = xm_q;
        mw_d     = mw_q;
        fxx_a_d  = fxx_a_q;
        fxx_b_d  = fxx_b_q;
        fxm_a_d  = fxm_a_q;
        fxm_b_d  = fxm_b_q;
        xx_sel_d = xx_sel_q;
        xm_sel_d = xm_sel_q;
        if (!bus.mem_stall) begin
            mw_d = xm_q;
            xm_d = dx_q;
            if (bubble) begin
                dx_d    = '0;
                fxx_a_d = 1'b0;
                fxx_b_d = 1'b0;
                fxm_a_d = 1'b0;
                fxm_b_d = 1'b0;
            end else begin
                dx_d.wen   = bus.dec_wen & bus.dec_valid;
                dx_d.rd    = bus.dec_rd;
                dx_d.wbsrc = bus.dec_wbsrc;
                fxx_a_d    = hit_xx_rs;
                fxx_b_d    = hit_xx_rt;
                fxm_a_d    = hit_xm_rs;
                fxm_b_d    = hit_xm_rt;
                if (hit_xx_rs | hit_xx_rt) xx_sel_d = dx_q.wbsrc;
                if (hit_xm_rs | hit_xm_rt) xm_sel_d = xm_q.wbsrc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q     <= '0;
            xm_q     <= '0;
            mw_q     <= '0;
            fxx_a_q  <= 1'b0;
            fxx_b_q  <= 1'b0;
            fxm_a_q  <= 1'b0;
            fxm_b_q  <= 1'b0;
            xx_sel_q <= 2'b00;
            xm_sel_q <= 2'b00;
        end else begin
            dx_q     <= dx_d;
            xm_q     <= xm_d;
            mw_q     <= mw_d;
            fxx_a_q  <= fxx_a_d;
            fxx_b_q  <= fxx_b_d;
            fxm_a_q  <= fxm_a_d;
            fxm_b_q  <= fxm_b_d;
            xx_sel_q <= xx_sel_d;
            xm_sel_q <= xm_sel_d;
        end
    end

    // MW has no consumer yet; it is tracked for a future writeback-forward path
    logic unused_mw;
    assign unused_mw = ^mw_q;

    assign bus.stall_dec      = stall_dec_c;
    assign bus.forward_XX_A   = fxx_a_q;
    assign bus.forward_XX_B   = fxx_b_q;
    assign bus.forward_XM_A   = fxm_a_q;
    assign bus.forward_XM_B   = fxm_b_q;
    assign bus.forward_XX_sel = xx_sel_q;
    assign bus.forward_XM_sel = xm_sel_q;

`ifdef FWD_PERF_EN
    logic [CNT_W-1:0] perf_stalls_q, perf_stalls_d, perf_fwds_q, perf_fwds_d;
    logic             any_hit;

    // Saturating counters; stall_dec already excludes mem_stall cycles
    always_comb begin
        any_hit       = hit_xx_rs | hit_xx_rt | hit_xm_rs | hit_xm_rt;
        perf_stalls_d = perf_stalls_q;
        perf_fwds_d   = perf_fwds_q;
        if (stall_dec_c && !(&perf_stalls_q)) perf_stalls_d = perf_stalls_q + CNT_W'(1);
        if (!bus.mem_stall && !bubble && any_hit && !(&perf_fwds_q))
            perf_fwds_d = perf_fwds_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stalls_q <= '0;
            perf_fwds_q   <= '0;
        end else begin
            perf_stalls_q <= perf_stalls_d;
            perf_fwds_q   <= perf_fwds_d;
        end
    end

    assign bus.perf_stalls = perf_stalls_q;
    assign bus.perf_fwds   = perf_fwds_q;
`else
    assign bus.perf_stalls = '0;
    assign bus.perf_fwds   = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed pipeline scenarios plus a randomized run
// against an in-flight-instruction reference model.
module tb_fwd_hazard_ctrl;
    localparam int unsigned REG_W = 3;
    localparam int unsigned CNT_W = 16;
`ifdef FWD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       wen;
        logic [2:0] rd;
        logic [1:0] src;
    } ins_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    ins_t older[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] rs, input logic urs,
                         input logic [2:0] rt, input logic urt, input logic [2:0] rd,
                         input logic wen, input logic [1:0] src, input logic fl, input logic ms);
        bus.dec_valid  = v;
        bus.dec_rs     = rs;
        bus.dec_use_rs = urs;
        bus.dec_rt     = rt;
        bus.dec_use_rt = urt;
        bus.dec_rd     = rd;
        bus.dec_wen    = wen;
        bus.dec_wbsrc  = src;
        bus.flush      = fl;
        bus.mem_stall  = ms;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // {XX_A, XX_B, XM_A, XM_B, XX_sel, XM_sel}
    function automatic logic [7:0] fwd_vec();
        return {bus.forward_XX_A, bus.forward_XX_B, bus.forward_XM_A, bus.forward_XM_B,
                bus.forward_XX_sel, bus.forward_XM_sel};
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (fwd_vec() !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_fwd: got %b expected %b", fwd_vec(), 8'h00);
        end
        n_checks++;
        if (bus.stall_dec !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stall: got %b expected 0", bus.stall_dec);
        end
        n_checks++;
        if (bus.perf_stalls !== '0 || bus.perf_fwds !== '0) begin
            n_errors++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", bus.perf_stalls, bus.perf_fwds);
        end
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (bus.stall_dec !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_stall: got %b expected 0", bus.stall_dec);
        end
        tick();
        idle();
        n_checks++;
        if (fwd_vec() !== 8'b1000_1100) begin
            n_errors++;
            $display("FAIL alu_fwd: got %b expected %b", fwd_vec(), 8'b1000_1100);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (bus.stall_dec !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_stall_on: got %b expected 1", bus.stall_dec);
        end
        tick();
        n_checks++;
        if (fwd_vec() !== 8'h00) begin
            n_errors++;
            $display("FAIL lu_bubble: got %b expected %b", fwd_vec(), 8'h00);
        end
        n_checks++;
        if (bus.stall_dec !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_stall_off: got %b expected 0", bus.stall_dec);
        end
        tick();
        idle();
        n_checks++;
        if (fwd_vec() !== 8'b0001_0010) begin
            n_errors++;
            $display("FAIL lu_xm_fwd: got %b expected %b", fwd_vec(), 8'b0001_0010);
        end
        n_checks++;
        if (bus.perf_stalls !== CNT_W'(PERF) || bus.perf_fwds !== CNT_W'(PERF)) begin
            n_errors++;
            $display("FAIL lu_perf: got %0d/%0d expected %0d/%0d",
                     bus.perf_stalls, bus.perf_fwds, PERF, PERF);
        end
    endtask

    task automatic test_jal_fwd();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        drive(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (bus.stall_dec !== 1'b0) begin
            n_errors++;
            $display("FAIL jal_stall: got %b expected 0", bus.stall_dec);
        end
        tick();
        idle();
        n_checks++;
        if (fwd_vec() !== 8'b0010_0001) begin
            n_errors++;
            $display("FAIL jal_fwd: got %b expected %b", fwd_vec(), 8'b0010_0001);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd6, 1'b0, 3'd5, 1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if (fwd_vec() !== 8'b1010_0011) begin
            n_errors++;
            $display("FAIL b2b_fwd: got %b expected %b", fwd_vec(), 8'b1010_0011);
        end
    endtask

    task automatic test_flush_loaduse();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 2'b11, 1'b1, 1'b0);
        n_checks++;
        if (bus.stall_dec !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_stall: got %b expected 0", bus.stall_dec);
        end
        tick();
        drive(1'b1, 3'd5, 1'b1, 3'd6, 1'b0, 3'd4, 1'b1, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (fwd_vec() !== 8'h00) begin
            n_errors++;
            $display("FAIL flush_fwd: got %b expected %b", fwd_vec(), 8'h00);
        end
        tick();
        idle();
        n_checks++;
        if (fwd_vec() !== 8'h00) begin
            n_errors++;
            $display("FAIL flush_dx_bubble: got %b expected %b", fwd_vec(), 8'h00);
        end
    endtask

    task automatic test_mem_stall_rst();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.stall_dec !== 1'b0) begin
                n_errors++;
                $display("FAIL ms_stall[%0d]: got %b expected 0", i, bus.stall_dec);
            end
            tick();
            n_checks++;
            if (fwd_vec() !== 8'b1000_1100) begin
                n_errors++;
                $display("FAIL ms_hold[%0d]: got %b expected %b", i, fwd_vec(), 8'b1000_1100);
            end
            n_checks++;
            if (bus.perf_stalls !== '0 || bus.perf_fwds !== CNT_W'(PERF)) begin
                n_errors++;
                $display("FAIL ms_perf[%0d]: got %0d/%0d expected 0/%0d",
                         i, bus.perf_stalls, bus.perf_fwds, PERF);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (fwd_vec() !== 8'h00 || bus.stall_dec !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_stall: got %b/%b expected 00000000/0", fwd_vec(), bus.stall_dec);
        end
        n_checks++;
        if (bus.perf_stalls !== '0 || bus.perf_fwds !== '0) begin
            n_errors++;
            $display("FAIL rst_perf: got %0d/%0d expected 0/0", bus.perf_stalls, bus.perf_fwds);
        end
        idle();
    endtask

    // Reference model: older[0] is the instruction heading into execute next,
    // older[1] the one behind it; a flushed or stalled slot enters as an empty record.
    task automatic test_random();
        ins_t             cur, young, elder;
        logic             v, urs, urt, fl, ms, rr, hold, ld, exp_stall;
        logic             hxa, hxb, hma, hmb;
        logic [2:0]       rs, rt;
        logic [7:0]       exp_v;
        logic [CNT_W-1:0] e_ps, e_pf;
        do_reset();
        older = {};
        for (int i = 0; i < 3; i++) older.push_back('0);
        exp_v = '0; e_ps = '0; e_pf = '0; hold = 1'b0;
        v = 1'b0; urs = 1'b0; urt = 1'b0; rs = '0; rt = '0; cur = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!hold) begin
                v       = ($urandom_range(0, 3) != 0);
                cur.rd  = 3'($urandom_range(0, 3));
                cur.wen = 1'($urandom_range(0, 1));
                cur.src = 2'($urandom_range(0, 3));
                rs      = 3'($urandom_range(0, 3));
                rt      = 3'($urandom_range(0, 3));
                urs     = v & 1'($urandom_range(0, 1));
                urt     = v & 1'($urandom_range(0, 1));
            end
            fl  = ($urandom_range(0, 9) == 0);
            ms  = ($urandom_range(0, 5) == 0);
            rr  = ($urandom_range(0, 59) == 0);
            rst = rr;
            drive(v, rs, urs, rt, urt, cur.rd, cur.wen, cur.src, fl, ms);
            young = older[0];
            elder = older[1];
            ld = v && young.wen && (young.src == 2'b10)
                 && ((urs && young.rd == rs) || (urt && young.rd == rt));
            exp_stall = ld && !fl && !ms;
            n_checks++;
            if (bus.stall_dec !== exp_stall) begin
                n_errors++;
                $display("FAIL rnd_stall@%0d: got %b expected %b", cyc, bus.stall_dec, exp_stall);
            end
            if (rr) begin
                older = {};
                for (int i = 0; i < 3; i++) older.push_back('0);
                exp_v = '0; e_ps = '0; e_pf = '0; hold = 1'b0;
            end else if (ms) begin
                hold = 1'b1;
            end else begin
                hxa = urs && young.wen && young.rd == rs && young.src != 2'b10;
                hxb = urt && young.wen && young.rd == rt && young.src != 2'b10;
                hma = urs && elder.wen && elder.rd == rs;
                hmb = urt && elder.wen && elder.rd == rt;
                if (fl || ld) begin
                    exp_v[7:4] = 4'b0000;
                    older.push_front('0);
                end else begin
                    exp_v[7:4] = {hxa, hxb, hma, hmb};
                    if (hxa || hxb) exp_v[3:2] = young.src;
                    if (hma || hmb) exp_v[1:0] = elder.src;
                    older.push_front('{wen: cur.wen & v, rd: cur.rd, src: cur.src});
                    if (PERF && (hxa || hxb || hma || hmb) && e_pf != '1) e_pf = e_pf + CNT_W'(1);
                end
                void'(older.pop_back());
                if (PERF && exp_stall && e_ps != '1) e_ps = e_ps + CNT_W'(1);
                hold = exp_stall;
            end
            tick();
            n_checks++;
            if (fwd_vec() !== exp_v) begin
                n_errors++;
                $display("FAIL rnd_fwd@%0d: got %b expected %b", cyc, fwd_vec(), exp_v);
            end
            n_checks++;
            if (bus.perf_stalls !== e_ps || bus.perf_fwds !== e_pf) begin
                n_errors++;
                $display("FAIL rnd_perf@%0d: got %0d/%0d expected %0d/%0d",
                         cyc, bus.perf_stalls, bus.perf_fwds, e_ps, e_pf);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_jal_fwd();
        test_back_to_back();
        test_flush_loaduse();
        test_mem_stall_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side partner of the execute stage's forwarding muxes. Produces forward_XX_A/B, forward_XM_A/B, forward_XX_sel and forward_XM_sel, all aligned to the cycle the consuming instruction occupies execute.
- Keeps a private three-slot shadow of the DX, XM and MW destination state. Detects load-use hazards and requests a one-cycle decode stall.
- Sits beside the decode stage. Consumes execute's flush and the memory stall.

Parameters:
- REG_W, 3, register specifier width (8 GPRs).
- CNT_W, 16, perf counter width (used only under FWD_PERF_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  decode holds a real instruction
- dec_rs  in  REG_W  decode source A specifier
- dec_rt  in  REG_W  decode source B specifier
- dec_use_rs  in  1  decode instruction reads rs
- dec_use_rt  in  1  decode instruction reads rt
- dec_rd  in  REG_W  decode destination
- dec_wen  in  1  decode instruction writes the register file
- dec_wbsrc  in  2  writeback source: 00 specOps, 01 pc_inc, 10 memData, 11 aluOut
- flush  in  1  branch/jump redirect from execute
- mem_stall  in  1  data memory busy; whole pipe frozen
- stall_dec  out  1  load-use stall; hold PC and FD; inject bubble into DX
- forward_XX_A, forward_XX_B, forward_XM_A, forward_XM_B  out  1 each  registered forward enables
- forward_XX_sel, forward_XM_sel  out  2 each  registered source selects (encoding = dec_wbsrc)
- perf_stalls, perf_fwds  out  CNT_W each  counters (zero without macro)

Behaviour:
- Shadow slots DX, XM, MW each hold {wen, rd, wbsrc}. Reset: all wen=0, rd=0, wbsrc=00. All outputs are 0 on the first cycle after reset.
- Normal advance (no mem_stall): MW<=XM, XM<=DX, DX<=decode fields (wen = dec_wen & dec_valid).
- Hazard terms, computed combinationally in decode against the current slots:
  - hitXX_s = use_s & DX.wen & DX.rd==s & DX.wbsrc!=10
  - hitXM_s = use_s & XM.wen & XM.rd==s
  - loaduse = dec_valid & (any use_s & DX.wen & DX.rd==s & DX.wbsrc==10)
- stall_dec = loaduse & ~flush & ~mem_stall. It is combinational, same cycle.
- Registered forward outputs update on advance:
  - forward_XX_A <= hitXX_rs, forward_XX_B <= hitXX_rt, forward_XX_sel <= DX.wbsrc.
  - forward_XM_A <= hitXM_rs, forward_XM_B <= hitXM_rt, forward_XM_sel <= XM.wbsrc.
  - Selects hold their previous value when the matching enables are both 0.
- XX and XM both asserted is legal. Execute gives XX priority (youngest producer).
- Load-use cycle: DX slot and all forward enables load 0 (bubble); XM/MW still advance. The next cycle re-evaluates the same decode instruction. The load is then in XM, so forward_XM_* is set with sel=10.
- Flush: DX slot and forward enables load 0 regardless of loaduse or dec_valid. XM/MW advance normally.
- mem_stall: every slot, output and counter holds. Priority is mem_stall > flush > loaduse.
- Register 0 is an ordinary register: no special casing.
- rst mid-operation clears all state on the next edge; a pending stall is dropped.

Optional Feature:
- FWD_PERF_EN defined:
  - perf_stalls increments on each cycle stall_dec=1.
  - perf_fwds increments on each advance where any forward enable is loaded 1.
  - Both counters saturate at all-ones, clear on rst, and hold during mem_stall.
- Undefined: no counter flops; both ports tied to 0.

Test Plan:
- ADD r1 (wbsrc 11) then SUB reading r1 as rs -> on SUB's execute cycle forward_XX_A=1, sel=11; all other enables 0; stall_dec never asserted.
- LD r2 (wbsrc 10) then ADD reading r2 as rt -> stall_dec=1 for exactly 1 cycle, bubble enables 0; next cycle forward_XM_B=1, sel=10, forward_XX_B=0.
- JAL writing r7 (wbsrc 01), NOP, consumer of r7 -> forward_XM_A=1, sel=01, no stall.
- Producers r3 (wbsrc 11) and r3 (wbsrc 00) back to back, consumer of r3 -> forward_XX_A=1 sel=00 and forward_XM_A=1 sel=11 together.
- flush coincident with load-use -> stall_dec=0, DX bubbled, no forward enables next cycle.
- mem_stall held 3 cycles mid-sequence -> outputs and counters unchanged; rst asserted mid-stall -> all outputs 0 next cycle; with FWD_PERF_EN after the load-use test, perf_stalls=1.
